uart_tx_serializer_p: RTL and testbench
=======================================

// Module: uart_tx_serializer_p
// PURPOSE
//  Parametrised parallel-to-serial shifter for the UART TX path.
//  Accepts one DATA_W-bit word per valid/ready handshake and shifts it out one bit
//  per bit_tick strobe, LSB- or MSB-first. Can append a parity bit, and returns
//  data_out to a programmable idle level between words.
//  Sits between the TX frame FSM (start/stop bits, baud generation) and the line driver.
// PARAMETERS
//  DATA_W     8  data bits per word, 2..16
//  MSB_FIRST  0  0: bit 0 shifted first; 1: bit DATA_W-1 shifted first
//  PARITY_EN  0  1: one parity bit is appended after the data bits
//  PARITY_ODD 0  0: even parity; 1: odd parity (ignored when PARITY_EN=0)
//  IDLE_LVL   1  data_out level when no word is in flight
// PORTS
//  clk         in   1                clock, rising edge
//  rst         in   1                async reset, active low
//  data_in     in   DATA_W           word to serialise
//  load_valid  in   1                data_in valid
//  load_ready  out  1                block can accept a word (high in IDLE)
//  bit_tick    in   1                one-cycle strobe marking the end of the current bit period
//  abort       in   1                synchronous abort of the word in flight
//  data_out    out  1                serial bit, registered
//  busy        out  1                word in flight (SHIFT or PARITY)
//  done        out  1                one-cycle pulse, word fully sent
//  bit_idx     out  $clog2(DATA_W+1) number of data bits already completed in the current word
// BEHAVIOUR
//  Reset (rst low, async): state=IDLE, shift_reg=0, cnt=0, parity=0,
//   data_out=IDLE_LVL, busy=0, done=0, load_ready=1, bit_idx=0.
//  States: IDLE, SHIFT, PARITY. busy=(state!=IDLE). load_ready=(state==IDLE).
//  IDLE:
//   - load_valid & load_ready: capture data_in and its parity
//     (XOR of all bits, inverted if PARITY_ODD); cnt=0; state->SHIFT.
//   - The next cycle, data_out = first bit (bit 0, or bit DATA_W-1 if MSB_FIRST).
//   - Load-to-first-bit latency is 1 clk.
//   - A bit_tick in the load cycle is ignored.
//  SHIFT, on bit_tick:
//   - cnt<DATA_W-1: cnt++; shift; data_out = next bit.
//   - cnt==DATA_W-1, PARITY_EN=1: state->PARITY; data_out = parity.
//   - cnt==DATA_W-1, PARITY_EN=0: state->IDLE; data_out=IDLE_LVL;
//     done=1 for exactly one cycle.
//  PARITY, on bit_tick: state->IDLE; data_out=IDLE_LVL; done=1 for one cycle.
//  No bit_tick: all state and data_out hold. Each bit lasts exactly one tick period.
//  bit_idx = cnt while in SHIFT; DATA_W while in PARITY; 0 in IDLE.
//  Word length on the line: DATA_W + PARITY_EN tick periods.
//  done is registered and coincides with the first IDLE cycle. load_ready is high
//   in that cycle, so a load in the done cycle is accepted (back-to-back words,
//   no gap bit).
//  load_valid while busy: ignored. No capture; the word in flight is unaffected.
//  abort (busy): next cycle state=IDLE, data_out=IDLE_LVL, cnt=0, done stays 0.
//   abort has priority over bit_tick in the same cycle. abort in IDLE has no effect;
//   a load in the same cycle as abort in IDLE is accepted.
//  Reset mid-word: immediate return to reset values; no done pulse.
//  Width rules: cnt is $clog2(DATA_W) bits and never exceeds DATA_W-1.
//   The shift register is exactly DATA_W bits; vacated bits fill with 0.
// TESTING
//  T1 DATA_W=8, LSB-first, no parity; load 0x0F, bit_tick every 4 clk
//     -> data_out 1,1,1,1,0,0,0,0; single done pulse after the 8th tick; then idle 1.
//  T2 MSB_FIRST=1, load 0x0F -> data_out 0,0,0,0,1,1,1,1; bit_idx steps 0..7.
//  T3 PARITY_EN=1: even parity, load 0x07 -> 8 data bits, then parity bit 1,
//     done after the 9th tick. Odd parity, same word -> parity bit 0.
//  T4 Abort asserted together with the 3rd bit_tick
//     -> next clk data_out=IDLE_LVL, busy=0, load_ready=1; no done pulse.
//  T5 load_valid held high with words 0x55 then 0xAA
//     -> second word accepted in the done cycle, no idle bit between words;
//     load_valid pulses while busy are ignored.
//  T6 rst low after the 5th tick -> data_out=IDLE_LVL and busy=0 immediately;
//     after release, a new load of 0x81 serialises correctly.

Source files
------------

// File: rtl/uart_tx_serializer_p.sv
// Parallel-to-serial shifter for the UART TX path: one DATA_W word per load handshake, one bit per bit_tick.
// Latency: first bit on o_data_out 1 clk after the load; each bit then lasts one tick period, plus an optional parity bit.
// Backpressure: o_load_ready is low while a word is in flight; load_valid is ignored until the done cycle, when it is high again.
module uart_tx_serializer_p #(
    parameter int unsigned DATA_W     = 8,
    parameter bit          MSB_FIRST  = 1'b0,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          PARITY_ODD = 1'b0,
    parameter bit          IDLE_LVL   = 1'b1,
    localparam int unsigned CNT_W     = $clog2(DATA_W),
    localparam int unsigned BI_W      = $clog2(DATA_W + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data_in,
    input  logic              i_load_valid,
    output logic              o_load_ready,
    input  logic              i_bit_tick,
    input  logic              i_abort,
    output logic              o_data_out,
    output logic              o_busy,
    output logic              o_done,
    output logic [BI_W-1:0]   o_bit_idx
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [DATA_W-1:0]  r_shift;
    logic [DATA_W-1:0]  w_shift_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_par;
    logic               w_par_nxt;
    logic               r_data_out;
    logic               w_dout_nxt;
    logic               r_done;
    logic               w_done_nxt;

    logic [DATA_W-1:0]  w_shifted;
    logic               w_next_bit;
    logic               w_load_bit;
    logic               w_last_bit;

    // The bit on the line is always the one at the outgoing end of r_shift.
    assign w_shifted  = MSB_FIRST ? {r_shift[DATA_W-2:0], 1'b0} : {1'b0, r_shift[DATA_W-1:1]};
    assign w_next_bit = MSB_FIRST ? w_shifted[DATA_W-1] : w_shifted[0];
    assign w_load_bit = MSB_FIRST ? i_data_in[DATA_W-1] : i_data_in[0];
    assign w_last_bit = (r_cnt == CNT_W'(DATA_W - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_par      <= 1'b0;
            r_data_out <= IDLE_LVL;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_par      <= w_par_nxt;
            r_data_out <= w_dout_nxt;
            r_done     <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_par_nxt   = r_par;
        w_dout_nxt  = r_data_out;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // abort is meaningless here; a same-cycle load still goes through
                if (i_load_valid) begin
                    w_shift_nxt = i_data_in;
                    w_par_nxt   = (^i_data_in) ^ PARITY_ODD;
                    w_cnt_nxt   = '0;
                    w_dout_nxt  = w_load_bit;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_dout_nxt  = IDLE_LVL;
                    w_cnt_nxt   = '0;
                end else if (i_bit_tick) begin
                    if (!w_last_bit) begin
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_shift_nxt = w_shifted;
                        w_dout_nxt  = w_next_bit;
                    end else if (PARITY_EN) begin
                        w_state_nxt = S_PARITY;
                        w_dout_nxt  = r_par;
                    end else begin
                        w_state_nxt = S_IDLE;
                        w_dout_nxt  = IDLE_LVL;
                        w_cnt_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_dout_nxt  = IDLE_LVL;
                    w_cnt_nxt   = '0;
                end else if (i_bit_tick) begin
                    w_state_nxt = S_IDLE;
                    w_dout_nxt  = IDLE_LVL;
                    w_cnt_nxt   = '0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_dout_nxt  = IDLE_LVL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        o_bit_idx = '0;
        case (r_state)
            S_SHIFT:  o_bit_idx = BI_W'(r_cnt);
            S_PARITY: o_bit_idx = BI_W'(DATA_W);
            default:  o_bit_idx = '0;
        endcase
    end

    assign o_load_ready = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_data_out   = r_data_out;
    assign o_done       = r_done;

endmodule

// File: tb/tb_uart_tx_serializer_p.sv
// Directed bench for uart_tx_serializer_p: four instances (LSB, MSB, even parity, odd parity) share one stimulus.
module tb_uart_tx_serializer_p;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       load_valid;
    logic       bit_tick;
    logic       abort;

    logic       dout [4];
    logic       busy [4];
    logic       done [4];
    logic       rdy  [4];
    logic [3:0] idx  [4];

    int n_vec;
    int n_err;

    // 0: LSB no parity, 1: MSB first, 2: even parity, 3: odd parity
    uart_tx_serializer_p #(.DATA_W(8)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(rdy[0]), .i_bit_tick(bit_tick), .i_abort(abort),
        .o_data_out(dout[0]), .o_busy(busy[0]), .o_done(done[0]), .o_bit_idx(idx[0]));
    uart_tx_serializer_p #(.DATA_W(8), .MSB_FIRST(1'b1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(rdy[1]), .i_bit_tick(bit_tick), .i_abort(abort),
        .o_data_out(dout[1]), .o_busy(busy[1]), .o_done(done[1]), .o_bit_idx(idx[1]));
    uart_tx_serializer_p #(.DATA_W(8), .PARITY_EN(1'b1)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(rdy[2]), .i_bit_tick(bit_tick), .i_abort(abort),
        .o_data_out(dout[2]), .o_busy(busy[2]), .o_done(done[2]), .o_bit_idx(idx[2]));
    uart_tx_serializer_p #(.DATA_W(8), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_data_in(data_in), .i_load_valid(load_valid),
        .o_load_ready(rdy[3]), .i_bit_tick(bit_tick), .i_abort(abort),
        .o_data_out(dout[3]), .o_busy(busy[3]), .o_done(done[3]), .o_bit_idx(idx[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; outputs are read on the falling edge too.
    task automatic step(input logic t);
        bit_tick = t;
        @(posedge clk);
        @(negedge clk);
        bit_tick = 1'b0;
    endtask

    task automatic tick4();
        repeat (3) step(1'b0);
        step(1'b1);
    endtask

    task automatic do_load(input logic [7:0] w);
        data_in    = w;
        load_valid = 1'b1;
        step(1'b0);
        load_valid = 1'b0;
    endtask

    task automatic flush();
        abort = 1'b1;
        step(1'b0);
        abort = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({dout[i], busy[i], done[i], rdy[i], idx[i]} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
                n_err++;
                $display("FAIL reset inst%0d: dout/busy/done/rdy/idx=%b%b%b%b/%0d expected 1001/0",
                         i, dout[i], busy[i], done[i], rdy[i], idx[i]);
            end
        end
    endtask

    task automatic test_lsb_msb();
        logic ea [8];
        logic eb [8];
        ea = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        eb = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        do_load(8'h0F);
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                repeat (3) begin
                    step(1'b0);
                    n_vec++;
                    if ({dout[0], done[0]} !== {ea[k-1], 1'b0}) begin
                        n_err++;
                        $display("FAIL lsb_hold k=%0d: dout/done=%b%b expected %b0", k, dout[0], done[0], ea[k-1]);
                    end
                end
                step(1'b1);
            end
            n_vec++;
            if ({dout[0], busy[0], done[0], idx[0]} !== {ea[k], 1'b1, 1'b0, 4'(k)}) begin
                n_err++;
                $display("FAIL lsb_bit k=%0d: dout/busy/done=%b%b%b idx=%0d expected %b10 idx=%0d",
                         k, dout[0], busy[0], done[0], idx[0], ea[k], k);
            end
            n_vec++;
            if ({dout[1], idx[1]} !== {eb[k], 4'(k)}) begin
                n_err++;
                $display("FAIL msb_bit k=%0d: dout=%b idx=%0d expected %b idx=%0d", k, dout[1], idx[1], eb[k], k);
            end
        end
        tick4();
        for (int i = 0; i < 2; i++) begin
            n_vec++;
            if ({dout[i], busy[i], done[i], rdy[i], idx[i]} !== {1'b1, 1'b0, 1'b1, 1'b1, 4'd0}) begin
                n_err++;
                $display("FAIL end_word inst%0d: dout/busy/done/rdy=%b%b%b%b idx=%0d expected 1011 idx=0",
                         i, dout[i], busy[i], done[i], rdy[i], idx[i]);
            end
        end
        step(1'b0);
        n_vec++;
        if ({dout[0], done[0]} !== 2'b10) begin
            n_err++;
            $display("FAIL done_width: dout/done=%b%b expected 10", dout[0], done[0]);
        end
        flush();
    endtask

    task automatic test_parity();
        logic e [8];
        e = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        do_load(8'h07);
        for (int k = 1; k < 8; k++) begin
            tick4();
            n_vec++;
            if ({dout[2], dout[3], idx[2]} !== {e[k], e[k], 4'(k)}) begin
                n_err++;
                $display("FAIL par_data k=%0d: dout even/odd=%b%b idx=%0d expected %b%b idx=%0d",
                         k, dout[2], dout[3], idx[2], e[k], e[k], k);
            end
        end
        tick4();
        n_vec++;
        if ({dout[2], dout[3], busy[2], done[2], idx[2], idx[3]} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd8, 4'd8}) begin
            n_err++;
            $display("FAIL par_bit: even/odd=%b%b busy=%b done=%b idx=%0d/%0d expected 10 busy=1 done=0 idx=8/8",
                     dout[2], dout[3], busy[2], done[2], idx[2], idx[3]);
        end
        tick4();
        for (int i = 2; i < 4; i++) begin
            n_vec++;
            if ({dout[i], busy[i], done[i], idx[i]} !== {1'b1, 1'b0, 1'b1, 4'd0}) begin
                n_err++;
                $display("FAIL par_end inst%0d: dout/busy/done=%b%b%b idx=%0d expected 101 idx=0",
                         i, dout[i], busy[i], done[i], idx[i]);
            end
        end
        flush();
    endtask

    task automatic test_abort();
        do_load(8'h0F);
        tick4();
        tick4();
        n_vec++;
        if ({dout[0], idx[0]} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL abort_pre: dout=%b idx=%0d expected 1 idx=2", dout[0], idx[0]);
        end
        repeat (3) step(1'b0);
        abort = 1'b1;
        step(1'b1);
        abort = 1'b0;
        n_vec++;
        if ({dout[0], busy[0], rdy[0], done[0], idx[0]} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL abort_now: dout/busy/rdy/done=%b%b%b%b idx=%0d expected 1010 idx=0",
                     dout[0], busy[0], rdy[0], done[0], idx[0]);
        end
        for (int k = 0; k < 8; k++) begin
            tick4();
            n_vec++;
            if ({dout[0], done[0], busy[0]} !== 3'b100) begin
                n_err++;
                $display("FAIL abort_after k=%0d: dout/done/busy=%b%b%b expected 100", k, dout[0], done[0], busy[0]);
            end
        end
        abort = 1'b1;
        do_load(8'h02);
        abort = 1'b0;
        n_vec++;
        if ({dout[0], busy[0], idx[0]} !== {1'b0, 1'b1, 4'd0}) begin
            n_err++;
            $display("FAIL abort_idle_load: dout/busy=%b%b idx=%0d expected 01 idx=0", dout[0], busy[0], idx[0]);
        end
        tick4();
        n_vec++;
        if ({dout[0], idx[0]} !== {1'b1, 4'd1}) begin
            n_err++;
            $display("FAIL abort_idle_bit1: dout=%b idx=%0d expected 1 idx=1", dout[0], idx[0]);
        end
        flush();
    endtask

    task automatic test_back_to_back();
        logic e5 [8];
        logic ea [8];
        e5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        ea = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        data_in    = 8'h55;
        load_valid = 1'b1;
        step(1'b0);
        data_in = 8'hAA;
        for (int k = 1; k < 8; k++) begin
            tick4();
            n_vec++;
            if ({dout[0], busy[0], rdy[0]} !== {e5[k], 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL b2b_w0 k=%0d: dout/busy/rdy=%b%b%b expected %b10", k, dout[0], busy[0], rdy[0], e5[k]);
            end
        end
        tick4();
        n_vec++;
        if ({dout[0], done[0], rdy[0]} !== 3'b111) begin
            n_err++;
            $display("FAIL b2b_done: dout/done/rdy=%b%b%b expected 111", dout[0], done[0], rdy[0]);
        end
        step(1'b0);
        load_valid = 1'b0;
        n_vec++;
        if ({dout[0], busy[0], done[0], idx[0]} !== {1'b0, 1'b1, 1'b0, 4'd0}) begin
            n_err++;
            $display("FAIL b2b_second_load: dout/busy/done=%b%b%b idx=%0d expected 010 idx=0",
                     dout[0], busy[0], done[0], idx[0]);
        end
        for (int k = 1; k < 8; k++) begin
            tick4();
            n_vec++;
            if (dout[0] !== ea[k]) begin
                n_err++;
                $display("FAIL b2b_w1 k=%0d: dout=%b expected %b", k, dout[0], ea[k]);
            end
        end
        tick4();
        n_vec++;
        if ({dout[0], done[0], busy[0]} !== 3'b110) begin
            n_err++;
            $display("FAIL b2b_w1_end: dout/done/busy=%b%b%b expected 110", dout[0], done[0], busy[0]);
        end
        flush();
    endtask

    task automatic test_reset_midword();
        logic e [8];
        e = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        do_load(8'h3C);
        repeat (5) tick4();
        n_vec++;
        if ({dout[0], idx[0]} !== {1'b1, 4'd5}) begin
            n_err++;
            $display("FAIL rst_pre: dout=%b idx=%0d expected 1 idx=5", dout[0], idx[0]);
        end
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if ({dout[i], busy[i], done[i], rdy[i], idx[i]} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0}) begin
                n_err++;
                $display("FAIL rst_mid inst%0d: dout/busy/done/rdy=%b%b%b%b idx=%0d expected 1001 idx=0",
                         i, dout[i], busy[i], done[i], rdy[i], idx[i]);
            end
        end
        step(1'b1);
        rst_n = 1'b1;
        step(1'b0);
        do_load(8'h81);
        n_vec++;
        if ({dout[0], busy[0]} !== {e[0], 1'b1}) begin
            n_err++;
            $display("FAIL rst_reload: dout/busy=%b%b expected %b1", dout[0], busy[0], e[0]);
        end
        for (int k = 1; k < 8; k++) begin
            tick4();
            n_vec++;
            if ({dout[0], idx[0]} !== {e[k], 4'(k)}) begin
                n_err++;
                $display("FAIL rst_word k=%0d: dout=%b idx=%0d expected %b idx=%0d", k, dout[0], idx[0], e[k], k);
            end
        end
        tick4();
        n_vec++;
        if ({dout[0], done[0], busy[0]} !== 3'b110) begin
            n_err++;
            $display("FAIL rst_word_end: dout/done/busy=%b%b%b expected 110", dout[0], done[0], busy[0]);
        end
        flush();
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        data_in    = 8'h00;
        load_valid = 1'b0;
        bit_tick   = 1'b0;
        abort      = 1'b0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        step(1'b0);
        test_lsb_msb();
        test_parity();
        test_abort();
        test_back_to_back();
        test_reset_midword();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
